// File: rtl/multicycle_control_if.sv
// Memory handshake between the multi-cycle control FSM
// and the unified instruction/data memory.
interface multicycle_control_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_read,
    output mem_write,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_read,
    input  mem_write,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle LEGv8 datapath:
// fetch/decode/execute/memory/writeback, retire count, halt.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [10:0]          opcode,
  input  logic                 zero,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic [1:0]           alu_op,
  output logic                 alu_src,
  output logic                 reg2loc,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 retire,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired_count
);

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    WB_R,
    EXEC_ADDR,
    MEM_RD,
    WB_LD,
    MEM_WR,
    EXEC_CBZ,
    EXEC_B,
    HALT
  } state_t;

  state_t state;
  state_t state_n;
  state_t done_n;

  logic is_r;
  logic is_ld;
  logic is_st;
  logic is_cbz;
  logic is_b;

  assign is_r   = opcode inside {11'b10001011000,
                                 11'b11001011000,
                                 11'b10001010000,
                                 11'b10101010000};
  assign is_ld  = opcode == 11'b11111000010;
  assign is_st  = opcode == 11'b11111000000;
  assign is_cbz = opcode[10:3] == 8'b10110100;
  assign is_b   = opcode[10:5] == 6'b000101;

  // Instruction boundary: drop to IDLE once run is released.
  assign done_n = run ? FETCH : IDLE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_count <= '0;
    end else if (retire) begin
      retired_count <= retired_count + 1'b1;
    end
  end

  always_comb begin
    state_n       = state;
    mem.mem_req   = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_op        = 2'b00;
    alu_src       = 1'b0;
    reg2loc       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    retire        = 1'b0;
    halted        = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) state_n = FETCH;
      end
      FETCH: begin
        mem.mem_req  = 1'b1;
        mem.mem_read = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_n  = DECODE;
        end
      end
      DECODE: begin
        unique case (1'b1)
          is_r:         state_n = EXEC_R;
          is_ld, is_st: state_n = EXEC_ADDR;
          is_cbz:       state_n = EXEC_CBZ;
          is_b:         state_n = EXEC_B;
          default:      state_n = HALT;
        endcase
      end
      EXEC_R: begin
        alu_op  = 2'b10;
        state_n = WB_R;
      end
      WB_R: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_n   = done_n;
      end
      EXEC_ADDR: begin
        alu_src = 1'b1;
        reg2loc = is_st;
        state_n = is_st ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem.mem_req  = 1'b1;
        mem.mem_read = 1'b1;
        if (mem.mem_ready) state_n = WB_LD;
      end
      WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_n    = done_n;
      end
      MEM_WR: begin
        mem.mem_req   = 1'b1;
        mem.mem_write = 1'b1;
        reg2loc       = 1'b1;
        if (mem.mem_ready) begin
          retire  = 1'b1;
          state_n = done_n;
        end
      end
      EXEC_CBZ: begin
        alu_op   = 2'b01;
        reg2loc  = 1'b1;
        pc_src   = 1'b1;
        pc_write = zero;
        retire   = 1'b1;
        state_n  = done_n;
      end
      EXEC_B: begin
        pc_src   = 1'b1;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_n  = done_n;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle LEGv8 datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives alu_op, which the ALU control decoder consumes alongside instruction bits 30/29/24.
- Handshakes with the unified instruction/data memory.
- Counts retired instructions and halts on illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  synchronous active-low reset
- run  input  1  level enable; FSM leaves IDLE only when high
- opcode  input  11  instruction bits 31:21, valid from the IR after FETCH
- zero  input  1  ALU zero flag, valid in EXEC_CBZ
- mem_ready  input  1  memory completion; sampled only while mem_req=1
- mem_req  output  1  memory request, held until mem_ready
- mem_read  output  1  read qualifier (FETCH, MEM_RD)
- mem_write  output  1  write qualifier (MEM_WR)
- ir_write  output  1  load IR; pulses in the cycle FETCH completes
- pc_write  output  1  PC update; pulses with ir_write (PC+4), in EXEC_B, and in EXEC_CBZ when taken
- pc_src  output  1  0=PC+4, 1=branch target register
- alu_op  output  2  00 add (address/PC+4), 01 pass B (CBZ), 10 R-type
- alu_src  output  1  0=register B, 1=sign-extended immediate
- reg2loc  output  1  1 selects Rt (bits 4:0) as read register 2 (STUR, CBZ)
- reg_write  output  1  register file write strobe (WB_R, WB_LD)
- mem_to_reg  output  1  1 selects memory data for writeback
- retire  output  1  one-cycle pulse when an instruction completes
- halted  output  1  sticky; set on illegal opcode
- retired_count  output  CNT_W  retired-instruction count, wraps at 2^CNT_W

Behaviour:
- Reset (rst_n low at clk edge):
  - state=IDLE, retired_count=0, halted=0.
  - All control outputs are 0.
  - Reset mid-instruction abandons the instruction; no pc_write or reg_write in the cycle after reset.
- Outputs are a Moore decode of the state register.
  - Exceptions: ir_write, pc_write and retire are qualified by mem_ready or zero as listed.
  - Every output not listed for a state is 0.
- IDLE -> FETCH when run=1; otherwise stay.
- FETCH: mem_req=1, mem_read=1, alu_op=00.
  - On mem_ready=1: ir_write=1, pc_write=1 (pc_src=0), -> DECODE.
  - Otherwise stay, holding all outputs stable.
- DECODE: alu_op=00 (branch target computation). Dispatch on opcode:
  - 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR -> EXEC_R.
  - 11111000010 LDUR, 11111000000 STUR -> EXEC_ADDR.
  - opcode[10:3]=10110100 CBZ -> EXEC_CBZ.
  - opcode[10:5]=000101 B -> EXEC_B.
  - Anything else -> HALT.
- EXEC_R: alu_op=10, alu_src=0 -> WB_R.
- WB_R: reg_write=1, mem_to_reg=0, retire=1 -> FETCH (or IDLE if run=0).
- EXEC_ADDR: alu_op=00, alu_src=1; reg2loc=1 for STUR.
  - LDUR -> MEM_RD; STUR -> MEM_WR.
- MEM_RD: mem_req=1, mem_read=1; -> WB_LD on mem_ready, else stay.
- WB_LD: reg_write=1, mem_to_reg=1, retire=1 -> FETCH/IDLE.
- MEM_WR: mem_req=1, mem_write=1, reg2loc=1.
  - On mem_ready: retire=1 -> FETCH/IDLE; else stay.
- EXEC_CBZ: alu_op=01, reg2loc=1, pc_src=1, pc_write=zero, retire=1 -> FETCH/IDLE.
- EXEC_B: pc_src=1, pc_write=1, retire=1 -> FETCH/IDLE.
- HALT: halted=1; all strobes 0; no retire; exits only via reset. run is ignored.
- run deasserted mid-instruction: the current instruction still completes; the FSM enters IDLE at the instruction boundary.
- mem_ready high outside FETCH/MEM_RD/MEM_WR is ignored.
- retired_count increments by 1 on each retire cycle; wraps modulo 2^CNT_W with no flag.
- Latency with mem_ready tied high:
  - R-type 4 cycles (FETCH, DECODE, EXEC_R, WB_R).
  - LDUR 5; STUR 4; CBZ 3; B 3.
  - Each memory-wait cycle adds 1.

Test Plan:
- Reset, run=1, mem_ready=1, opcode=10001011000 (ADD) -> states FETCH, DECODE, EXEC_R, WB_R; alu_op=10 in EXEC_R; reg_write=1 and retire=1 on cycle 4; retired_count=1.
- LDUR with mem_ready low for 3 cycles in MEM_RD -> mem_req/mem_read held stable for 4 cycles; then WB_LD with mem_to_reg=1; total 8 cycles.
- CBZ with zero=1, then CBZ with zero=0 -> alu_op=01 in EXEC_CBZ; pc_write=1 (pc_src=1) only for the first; both retire.
- STUR then B -> reg2loc=1 and mem_write=1 in MEM_WR, with no reg_write; B gives pc_write=1, pc_src=1; retired_count=2.
- opcode=00000000000 -> HALT, halted=1; no further mem_req despite run=1; rst_n low for one edge clears halted and count, FSM returns to IDLE.
- CNT_W=4, fifteen B instructions then one more -> retired_count 15 -> 0; rst_n asserted during MEM_WR -> mem_write=0 and IDLE the next cycle.
